// File: rtl/axi4_stream_pkt_frag_tag.sv
// rtl/axi4_stream_pkt_frag_tag.sv - byte-accurate AXI4-Stream fragmenter with first/last/index tags on tuser; `AXI4_STREAM_FRAG_STATS_EN adds packet/fragment counters
module axi4_stream_pkt_frag_tag #(
    parameter int TDATA_WIDTH         = 64,
    parameter int TID_WIDTH           = 1,
    parameter int TDEST_WIDTH         = 1,
    parameter int FRAG_IDX_WIDTH      = 8,
    parameter int TUSER_WIDTH         = FRAG_IDX_WIDTH + 2,
    parameter int MAX_FRAG_SIZE       = 2048,
    parameter int MAX_FRAG_SIZE_WIDTH = $clog2(MAX_FRAG_SIZE)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [MAX_FRAG_SIZE_WIDTH:0]   max_frag_size_i,
    input  logic [TDATA_WIDTH-1:0]         pkt_i_tdata,
    input  logic [TDATA_WIDTH/8-1:0]       pkt_i_tkeep,
    input  logic [TDATA_WIDTH/8-1:0]       pkt_i_tstrb,
    input  logic                           pkt_i_tlast,
    input  logic [TID_WIDTH-1:0]           pkt_i_tid,
    input  logic [TDEST_WIDTH-1:0]         pkt_i_tdest,
    input  logic                           pkt_i_tvalid,
    output logic                           pkt_i_tready,
    output logic [TDATA_WIDTH-1:0]         pkt_o_tdata,
    output logic [TDATA_WIDTH/8-1:0]       pkt_o_tkeep,
    output logic [TDATA_WIDTH/8-1:0]       pkt_o_tstrb,
    output logic                           pkt_o_tlast,
    output logic [TUSER_WIDTH-1:0]         pkt_o_tuser,
    output logic [TID_WIDTH-1:0]           pkt_o_tid,
    output logic [TDEST_WIDTH-1:0]         pkt_o_tdest,
    output logic                           pkt_o_tvalid,
    input  logic                           pkt_o_tready
`ifdef AXI4_STREAM_FRAG_STATS_EN
    ,
    input  logic                           stats_clr_i,
    output logic [31:0]                    pkt_cnt_o,
    output logic [31:0]                    frag_cnt_o
`endif
);

    localparam int W_B   = TDATA_WIDTH / 8;
    localparam int BUF_B = 2 * W_B;
    localparam int BUF_W = 8 * BUF_B;
    localparam int CNT_W = $clog2(BUF_B + 1);
    localparam int FS_W  = MAX_FRAG_SIZE_WIDTH + 1;

    // Byte buffer: byte 0 of the vector is the oldest byte; bytes at or above cnt_q are kept zero.
    logic [BUF_W-1:0]          data_q, data_d;
    logic [BUF_B-1:0]          strb_q, strb_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      eop_q, sop_q, rdy_q, first_q, hold_q, last_hold_q;
    logic [FS_W-1:0]           fsize_q, fleft_q, fsize_eff;
    logic [FRAG_IDX_WIDTH-1:0] idx_q;
    logic [TID_WIDTH-1:0]      tid_q;
    logic [TDEST_WIDTH-1:0]    tdest_q;
    logic [TDATA_WIDTH-1:0]    in_data;
    logic [W_B-1:0]            in_strb;
    logic                      rx_hs, tx_hs, pkt_end, last_now, frag_last;
    int                        cnt_i, fleft_i, tx_i, rx_i, txn, rxn;

    // Beat sizing: bytes leaving now is bounded by bus width, buffered bytes and fragment room.
    always_comb begin
        cnt_i   = int'(cnt_q);
        fleft_i = int'(fleft_q);
        tx_i    = W_B;
        if (cnt_i < tx_i)   tx_i = cnt_i;
        if (fleft_i < tx_i) tx_i = fleft_i;
        rx_i = 0;
        for (int j = 0; j < W_B; j++) begin
            if (pkt_i_tkeep[j]) rx_i = rx_i + 1;
        end
        fsize_eff = max_frag_size_i;
        if (max_frag_size_i == '0 || max_frag_size_i > FS_W'(MAX_FRAG_SIZE))
            fsize_eff = FS_W'(MAX_FRAG_SIZE);
    end

    // The last-of-packet flag is only provable once tlast is buffered and the rest fits this
    // fragment; it is frozen while a beat is stalled so the presented tuser never changes.
    always_comb begin
        last_now     = eop_q && (cnt_i <= fleft_i);
        frag_last    = hold_q ? last_hold_q : last_now;
        pkt_i_tready = rdy_q && (cnt_i <= W_B) && !eop_q;
        pkt_o_tvalid = (tx_i > 0) && ((tx_i == W_B) || (tx_i == fleft_i) || eop_q);
        pkt_o_tlast  = pkt_o_tvalid && ((tx_i == fleft_i) || (eop_q && (tx_i == cnt_i)));
        pkt_o_tuser  = pkt_o_tvalid ? {first_q, frag_last, idx_q} : '0;
        pkt_o_tid    = tid_q;
        pkt_o_tdest  = tdest_q;
        for (int j = 0; j < W_B; j++) begin
            pkt_o_tkeep[j]       = (j < tx_i);
            pkt_o_tstrb[j]       = (j < tx_i) && strb_q[j];
            pkt_o_tdata[8*j +: 8] = (j < tx_i) ? data_q[8*j +: 8] : 8'h00;
        end
    end

    assign rx_hs   = pkt_i_tvalid && pkt_i_tready;
    assign tx_hs   = pkt_o_tvalid && pkt_o_tready;
    assign pkt_end = tx_hs && eop_q && (tx_i == cnt_i);

    // Buffer update: drop departing bytes from the bottom, append arriving bytes after what remains.
    always_comb begin
        in_data = '0;
        in_strb = '0;
        for (int j = 0; j < W_B; j++) begin
            if (pkt_i_tkeep[j]) begin
                in_data[8*j +: 8] = pkt_i_tdata[8*j +: 8];
                in_strb[j]        = pkt_i_tstrb[j];
            end
        end
        txn    = tx_hs ? tx_i : 0;
        rxn    = rx_hs ? rx_i : 0;
        data_d = data_q >> (8 * txn);
        strb_d = strb_q >> txn;
        if (rx_hs) begin
            data_d = data_d | ({{(BUF_W - TDATA_WIDTH){1'b0}}, in_data} << (8 * (cnt_i - txn)));
            strb_d = strb_d | ({{(BUF_B - W_B){1'b0}}, in_strb} << (cnt_i - txn));
        end
        cnt_d = CNT_W'(cnt_i - txn + rxn);
    end

    // Packet/fragment bookkeeping: size and routing latched at start of packet, index per fragment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q      <= '0;
            strb_q      <= '0;
            cnt_q       <= '0;
            eop_q       <= 1'b0;
            sop_q       <= 1'b1;
            rdy_q       <= 1'b0;
            first_q     <= 1'b1;
            hold_q      <= 1'b0;
            last_hold_q <= 1'b0;
            fsize_q     <= '0;
            fleft_q     <= '0;
            idx_q       <= '0;
            tid_q       <= '0;
            tdest_q     <= '0;
        end else begin
            rdy_q       <= 1'b1;
            data_q      <= data_d;
            strb_q      <= strb_d;
            cnt_q       <= cnt_d;
            hold_q      <= pkt_o_tvalid && !pkt_o_tready;
            last_hold_q <= frag_last;
            if (rx_hs) begin
                sop_q <= pkt_i_tlast;
                if (pkt_i_tlast) eop_q <= 1'b1;
                if (sop_q) begin
                    fsize_q <= fsize_eff;
                    fleft_q <= fsize_eff;
                    tid_q   <= pkt_i_tid;
                    tdest_q <= pkt_i_tdest;
                end
            end
            if (tx_hs) begin
                if (pkt_end) begin
                    eop_q   <= 1'b0;
                    idx_q   <= '0;
                    first_q <= 1'b1;
                end else if (pkt_o_tlast) begin
                    fleft_q <= fsize_q;
                    idx_q   <= idx_q + 1'b1;
                    first_q <= 1'b0;
                end else begin
                    fleft_q <= fleft_q - FS_W'(tx_i);
                end
            end
        end
    end

`ifdef AXI4_STREAM_FRAG_STATS_EN
    // Counters of completed packets and emitted fragments; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_cnt_o  <= '0;
            frag_cnt_o <= '0;
        end else if (stats_clr_i) begin
            pkt_cnt_o  <= '0;
            frag_cnt_o <= '0;
        end else if (tx_hs && pkt_o_tlast) begin
            frag_cnt_o <= frag_cnt_o + 32'd1;
            if (frag_last) pkt_cnt_o <= pkt_cnt_o + 32'd1;
        end
    end
`endif

endmodule
